// File: rtl/rr_arbiter_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_wrr
//  Description : Weighted round-robin arbiter for N requesters sharing one
//                downstream (L2) port, one outstanding transaction at a time.
//                Optional starvation guard compiled in with the macro
//                ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_wrr #(
    parameter int N            = 4,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int WW           = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*AW-1:0]   req_addr,
    input  logic [N-1:0]      req_we,
    input  logic [N*DW-1:0]   req_wdata,
    input  logic [N-1:0]      req_ll,
    input  logic [N-1:0]      req_sc,
    input  logic [N*WW-1:0]   weight,
    output logic [N-1:0]      rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_sc_success,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [AW-1:0]     l2_addr,
    output logic              l2_we,
    output logic [DW-1:0]     l2_wdata,
    output logic              l2_ll,
    output logic              l2_sc,
    input  logic              l2_rsp_valid,
    input  logic [DW-1:0]     l2_rsp_rdata,
    input  logic              l2_rsp_sc_success
);

    localparam int c_PW = (N > 1) ? $clog2(N) : 1;
    localparam int c_SW = c_PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_PW-1:0]   r_rr_ptr;
    logic [WW-1:0]     r_burst_cnt;
    logic [WW-1:0]     r_burst_lim;
    logic [c_PW-1:0]   r_owner;
    logic [AW-1:0]     r_addr;
    logic              r_we;
    logic [DW-1:0]     r_wdata;
    logic              r_ll;
    logic              r_sc;

    logic [c_SW-1:0]   w_scan;
    logic              w_rr_found;
    logic [c_PW-1:0]   w_rr_idx;
    logic              w_starved;
    logic [c_PW-1:0]   w_starve_idx;
    logic [c_PW-1:0]   w_win_idx;
    logic [c_PW-1:0]   w_ptr_inc;
    logic [WW-1:0]     w_win_weight;
    logic [WW-1:0]     w_lim;
    logic [WW-1:0]     w_cnt_inc;
    logic              w_burst_end;
    logic              w_grant;
    logic              w_rsp_fire;

    // Round-robin scan: first valid port at or after the pointer, modulo N
    always_comb begin
        w_scan     = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_rr_ptr} + c_SW'(k);
            if (w_scan >= c_SW'(N)) begin
                w_scan = w_scan - c_SW'(N);
            end
            if (!w_rr_found && req_valid[w_scan[c_PW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan[c_PW-1:0];
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int          c_CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_SL  = c_CW'(STARVE_LIMIT);
    localparam logic [c_CW-1:0] c_MAX = {c_CW{1'b1}};

    logic [c_CW-1:0] r_wait_cnt [N];

    // Per-port wait counters: count cycles spent valid but not accepted
    generate
        for (genvar g = 0; g < N; g++) begin : g_wait_cnt
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wait_cnt[g] <= '0;
                end else if (req_ready[g]) begin
                    r_wait_cnt[g] <= '0;
                end else if (req_valid[g] && (r_wait_cnt[g] != c_MAX)) begin
                    r_wait_cnt[g] <= r_wait_cnt[g] + 1'b1;
                end
            end
        end
    endgenerate

    // Lowest-index starved port overrides the round-robin choice
    always_comb begin
        w_starved    = 1'b0;
        w_starve_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (r_wait_cnt[i] >= c_SL)) begin
                w_starved    = 1'b1;
                w_starve_idx = c_PW'(i);
            end
        end
    end
`else
    assign w_starved    = 1'b0;
    assign w_starve_idx = '0;
`endif

    assign w_win_idx    = w_starved ? w_starve_idx : w_rr_idx;
    assign w_ptr_inc    = (w_win_idx == c_PW'(N - 1)) ? '0 : (w_win_idx + 1'b1);
    assign w_win_weight = weight[w_win_idx*WW +: WW];
    // The limit is sampled only when a burst starts; mid-burst weight edits wait
    assign w_lim        = (r_burst_cnt != '0) ? r_burst_lim :
                          ((w_win_weight == '0) ? WW'(1) : w_win_weight);
    assign w_cnt_inc    = r_burst_cnt + 1'b1;
    assign w_burst_end  = w_starved || (w_win_idx != r_rr_ptr) || (w_cnt_inc >= w_lim);
    assign w_grant      = rst_n && (r_state == ST_IDLE) && w_rr_found;
    assign w_rsp_fire   = rst_n && (r_state == ST_WAIT) && l2_rsp_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; everything forced low while in reset
    always_comb begin
        w_state_nxt    = r_state;
        req_ready      = '0;
        rsp_valid      = '0;
        rsp_rdata      = '0;
        rsp_sc_success = 1'b0;
        l2_req_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    req_ready   = N'(1) << w_win_idx;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                l2_req_valid = rst_n;
                if (l2_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_rsp_fire) begin
                    rsp_valid      = N'(1) << r_owner;
                    rsp_rdata      = l2_rsp_rdata;
                    rsp_sc_success = l2_rsp_sc_success;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pointer and burst bookkeeping, updated once per grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_burst_lim <= '0;
        end else if (w_grant) begin
            if (w_burst_end) begin
                r_rr_ptr    <= w_ptr_inc;
                r_burst_cnt <= '0;
            end else begin
                r_burst_cnt <= w_cnt_inc;
            end
            r_burst_lim <= w_lim;
        end
    end

    // Capture the winner's request so later requester changes cannot disturb it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_ll    <= 1'b0;
            r_sc    <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_win_idx;
            r_addr  <= req_addr[w_win_idx*AW +: AW];
            r_we    <= req_we[w_win_idx];
            r_wdata <= req_wdata[w_win_idx*DW +: DW];
            r_ll    <= req_ll[w_win_idx];
            r_sc    <= req_sc[w_win_idx];
        end
    end

    assign l2_addr  = r_addr;
    assign l2_we    = r_we;
    assign l2_wdata = r_wdata;
    assign l2_ll    = r_ll;
    assign l2_sc    = r_sc;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_wrr
//  Description : Self-checking bench for rr_arbiter_wrr with a transaction-
//                level weighted round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_wrr;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int SL = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, req_ll, req_sc, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*WW-1:0] weight;
    logic [DW-1:0]   rsp_rdata, l2_wdata, l2_rsp_rdata;
    logic [AW-1:0]   l2_addr;
    logic            rsp_sc_success, l2_req_valid, l2_req_ready, l2_we, l2_ll, l2_sc;
    logic            l2_rsp_valid, l2_rsp_sc_success;

    rr_arbiter_wrr #(.N(N), .AW(AW), .DW(DW), .WW(WW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_ll(req_ll),
        .req_sc(req_sc), .weight(weight), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_sc_success(rsp_sc_success), .l2_req_valid(l2_req_valid),
        .l2_req_ready(l2_req_ready), .l2_addr(l2_addr), .l2_we(l2_we), .l2_wdata(l2_wdata),
        .l2_ll(l2_ll), .l2_sc(l2_sc), .l2_rsp_valid(l2_rsp_valid),
        .l2_rsp_rdata(l2_rsp_rdata), .l2_rsp_sc_success(l2_rsp_sc_success)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pointer, grants so far in the burst, burst length
    int m_ptr, m_run, m_lim;
    int m_wait [N];

    // Per-port request contents offered this transaction
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];
    logic          t_we [N], t_ll [N], t_sc [N];

    // Observations gathered by drive_txn
    logic [N-1:0]  o_rdy, o_rspv;
    logic          o_l2v_all, o_stable, o_pre, o_we, o_ll, o_sc, o_rsc, x_rsc;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rdata, x_rdata;

    function automatic int weight_of(input int p);
        int v;
        v = int'(weight[p*WW +: WW]);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int model_pick(input logic [N-1:0] mask, output bit starved);
        starved = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < N; i++)
            if (mask[i] && m_wait[i] >= SL) begin
                starved = 1'b1;
                return i;
            end
`endif
        for (int k = 0; k < N; k++)
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_commit(input int w, input bit st, input logic [N-1:0] mask,
                                input int cyc, input bit drop);
        if (st || w != m_ptr) begin
            m_ptr = (w + 1) % N;
            m_run = 0;
        end else begin
            if (m_run == 0) m_lim = weight_of(w);
            m_run++;
            if (m_run >= m_lim) begin
                m_ptr = (w + 1) % N;
                m_run = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == w) m_wait[i] = drop ? 0 : cyc - 1;
            else if (mask[i]) m_wait[i] += drop ? 1 : cyc;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; l2_req_ready = 1'b0; l2_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0; m_run = 0; m_lim = 1;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    task automatic new_fields();
        for (int i = 0; i < N; i++) begin
            t_addr[i] = $urandom; t_wdata[i] = $urandom;
            t_we[i] = 1'($urandom); t_ll[i] = 1'($urandom); t_sc[i] = 1'($urandom);
        end
    endtask

    // One full transaction: grant cycle, issue cycles, wait cycles
    task automatic drive_txn(input logic [N-1:0] mask, input int rdly, input int sdly,
                             input bit stray, input bit drop);
        @(negedge clk);
        l2_rsp_valid = 1'b0;
        req_valid = mask;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = t_addr[i]; req_wdata[i*DW +: DW] = t_wdata[i];
            req_we[i] = t_we[i]; req_ll[i] = t_ll[i]; req_sc[i] = t_sc[i];
        end
        #2 o_rdy = req_ready;
        o_stable = 1'b1; o_l2v_all = 1'b1; o_pre = 1'b0;
        for (int c = 0; c <= rdly; c++) begin
            @(negedge clk);
            if (drop) req_valid = '0;
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW] = $urandom; req_wdata[i*DW +: DW] = $urandom;
            end
            req_we = N'($urandom); req_ll = N'($urandom); req_sc = N'($urandom);
            l2_req_ready = (c == rdly);
            l2_rsp_valid = stray;
            l2_rsp_rdata = $urandom;
            #2;
            if (c == 0) begin
                o_addr = l2_addr; o_wdata = l2_wdata; o_we = l2_we; o_ll = l2_ll; o_sc = l2_sc;
            end else if ({o_addr, o_wdata, o_we, o_ll, o_sc} !== {l2_addr, l2_wdata, l2_we, l2_ll, l2_sc}) begin
                o_stable = 1'b0;
            end
            if (l2_req_valid !== 1'b1) o_l2v_all = 1'b0;
            if (|rsp_valid) o_pre = 1'b1;
        end
        for (int c = 0; c <= sdly; c++) begin
            @(negedge clk);
            l2_req_ready = 1'b0;
            l2_rsp_valid = (c == sdly);
            l2_rsp_rdata = $urandom;
            l2_rsp_sc_success = 1'($urandom);
            #2;
            if (c < sdly) begin
                if (|rsp_valid) o_pre = 1'b1;
            end else begin
                o_rspv = rsp_valid; o_rdata = rsp_rdata; o_rsc = rsp_sc_success;
                x_rdata = l2_rsp_rdata; x_rsc = l2_rsp_sc_success;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #2;
            n_checks++;
            if ({req_ready, rsp_valid, l2_req_valid, l2_addr, l2_we, l2_wdata, l2_ll, l2_sc,
                 rsp_rdata, rsp_sc_success} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got rdy=%b rspv=%b l2v=%b addr=%h rdata=%h, expected all zero",
                         c, req_ready, rsp_valid, l2_req_valid, l2_addr, rsp_rdata);
            end
        end
        new_fields();
        drive_txn(4'b0001, 0, 0, 0, 0);
        n_checks++;
        if (o_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 0001", o_rdy);
        end
    endtask

    task automatic test_rr_equal();
        int tab [5] = '{0, 1, 2, 3, 0};
        int w;
        bit st;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int g = 0; g < 5; g++) begin
            new_fields();
            w = model_pick(4'b1111, st);
`ifndef ARB_STARVE_GUARD_EN
            w = tab[g];
`endif
            drive_txn(4'b1111, 0, 0, 0, 0);
            model_commit(w, st, 4'b1111, 3, 0);
            n_checks++;
            if (o_rdy !== (4'b0001 << w)) begin
                n_fail++;
                $display("FAIL rr_equal grant %0d: got %b expected port %0d", g, o_rdy, w);
            end
            n_checks++;
            if (o_rspv !== (4'b0001 << w)) begin
                n_fail++;
                $display("FAIL rr_equal rsp %0d: got %b expected port %0d", g, o_rspv, w);
            end
        end
    endtask

    task automatic test_weighted();
        int tab [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        int w;
        bit st;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        for (int g = 0; g < 9; g++) begin
            new_fields();
            w = model_pick(4'b1111, st);
`ifndef ARB_STARVE_GUARD_EN
            w = tab[g];
`endif
            drive_txn(4'b1111, 0, 0, 0, 0);
            model_commit(w, st, 4'b1111, 3, 0);
            n_checks++;
            if (o_rdy !== (4'b0001 << w)) begin
                n_fail++;
                $display("FAIL weighted grant %0d: got %b expected port %0d", g, o_rdy, w);
            end
        end
    endtask

    task automatic test_l2_stall();
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        new_fields();
        drive_txn(4'b0100, 5, 2, 0, 1);
        n_checks++;
        if (o_rdy !== 4'b0100) begin
            n_fail++; $display("FAIL stall_grant: got %b expected 0100", o_rdy);
        end
        n_checks++;
        if (!o_l2v_all || !o_stable) begin
            n_fail++; $display("FAIL stall_hold: got valid_held=%b stable=%b expected 1 1", o_l2v_all, o_stable);
        end
        n_checks++;
        if ({o_addr, o_wdata, o_we, o_ll, o_sc} !== {t_addr[2], t_wdata[2], t_we[2], t_ll[2], t_sc[2]}) begin
            n_fail++;
            $display("FAIL stall_fields: got addr=%h wdata=%h expected addr=%h wdata=%h", o_addr, o_wdata, t_addr[2], t_wdata[2]);
        end
        n_checks++;
        if (o_pre !== 1'b0 || o_rspv !== 4'b0100 || o_rdata !== x_rdata || o_rsc !== x_rsc) begin
            n_fail++;
            $display("FAIL stall_rsp: got rspv=%b rdata=%h sc=%b early=%b expected 0100 %h %b 0",
                     o_rspv, o_rdata, o_rsc, o_pre, x_rdata, x_rsc);
        end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        new_fields();
        @(negedge clk);
        req_valid = 4'b0100;
        #2;
        @(negedge clk);
        req_valid = '0; l2_req_ready = 1'b1;
        #2;
        n_checks++;
        if (l2_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_issue: got l2_req_valid=%b expected 1", l2_req_valid);
        end
        @(negedge clk);
        l2_req_ready = 1'b0; rst_n = 1'b0; l2_rsp_valid = 1'b1; l2_rsp_rdata = $urandom;
        #2;
        n_checks++;
        if ({rsp_valid, rsp_rdata, rsp_sc_success, l2_req_valid, req_ready} !== '0) begin
            n_fail++; $display("FAIL rst_wait_during: got rspv=%b rdata=%h expected 0", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (rsp_valid !== '0 || l2_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_stray: got rspv=%b l2v=%b expected 0 0", rsp_valid, l2_req_valid);
        end
        @(negedge clk);
        l2_rsp_valid = 1'b0; req_valid = 4'b0010;
        #2;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rst_wait_idle: got %b expected 0010", req_ready);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int w, rd, sd;
        bit st, stray;
        apply_reset();
        weight = N*WW'($urandom);
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) weight = N*WW'($urandom);
            mask = N'($urandom_range(0, 15));
            stray = 1'($urandom);
            new_fields();
            if (mask == '0) begin
                @(negedge clk);
                req_valid = '0; l2_rsp_valid = stray;
                #2;
                n_checks++;
                if (req_ready !== '0 || rsp_valid !== '0) begin
                    n_fail++; $display("FAIL rand_idle %0d: got rdy=%b rspv=%b expected 0 0", t, req_ready, rsp_valid);
                end
                continue;
            end
            rd = $urandom_range(0, 3);
            sd = $urandom_range(0, 2);
            w = model_pick(mask, st);
            drive_txn(mask, rd, sd, stray, 0);
            model_commit(w, st, mask, 3 + rd + sd, 0);
            n_checks++;
            if (o_rdy !== (N'(1) << w)) begin
                n_fail++; $display("FAIL rand_grant %0d: got %b expected port %0d (mask %b)", t, o_rdy, w, mask);
            end
            n_checks++;
            if ({o_addr, o_wdata, o_we, o_ll, o_sc} !== {t_addr[w], t_wdata[w], t_we[w], t_ll[w], t_sc[w]}
                || !o_stable || !o_l2v_all) begin
                n_fail++; $display("FAIL rand_l2 %0d: got addr=%h stable=%b expected addr=%h stable=1", t, o_addr, o_stable, t_addr[w]);
            end
            n_checks++;
            if (o_pre !== 1'b0 || o_rspv !== (N'(1) << w) || o_rdata !== x_rdata || o_rsc !== x_rsc) begin
                n_fail++; $display("FAIL rand_rsp %0d: got rspv=%b rdata=%h early=%b expected port %0d %h", t, o_rspv, o_rdata, o_pre, w, x_rdata);
            end
        end
    endtask

`ifdef ARB_STARVE_GUARD_EN
    task automatic test_starve();
        int w, wait3;
        bit st, got3;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd15};
        wait3 = 0; got3 = 1'b0;
        for (int g = 0; g < 8 && !got3; g++) begin
            new_fields();
            w = model_pick(4'b1001, st);
            drive_txn(4'b1001, 0, 0, 0, 0);
            model_commit(w, st, 4'b1001, 3, 0);
            n_checks++;
            if (o_rdy !== (4'b0001 << w)) begin
                n_fail++; $display("FAIL starve_grant %0d: got %b expected port %0d", g, o_rdy, w);
            end
            if (wait3 >= SL) begin
                n_checks++;
                if (o_rdy !== 4'b1000) begin
                    n_fail++; $display("FAIL starve_deadline: got %b expected 1000", o_rdy);
                end
            end
            if (o_rdy === 4'b1000) got3 = 1'b1;
            wait3 += 3;
        end
        n_checks++;
        if (!got3) begin
            n_fail++; $display("FAIL starve_never: got no grant to port 3, expected one");
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
        req_ll = '0; req_sc = '0; weight = '0; l2_req_ready = 1'b0; l2_rsp_valid = 1'b0;
        l2_rsp_rdata = '0; l2_rsp_sc_success = 1'b0;
        test_reset();
        test_rr_equal();
        test_weighted();
        test_l2_stall();
        test_reset_in_wait();
        test_random();
`ifdef ARB_STARVE_GUARD_EN
        test_starve();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
